// File: rtl/btb_sa_predictor.sv
// btb_sa_predictor: set-associative branch target buffer with per-entry
// saturating direction counters, per-set round-robin victim pointers,
// a synchronous flush and a saturating mispredict counter.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               invalidate every entry at the next edge
//   pc_fetch            IF-stage PC to look up (combinational)
//   pred_hit            valid tag match in the indexed set
//   pred_taken          hit and counter MSB set
//   pred_target         stored target when predicted taken, else pc_fetch+4
//   update_en           ID resolved a conditional branch this cycle
//   update_pc           PC of the resolved branch
//   update_taken        actual direction
//   update_target       actual taken target
//   update_mispredict   IF prediction was wrong (qualified by update_en)
//   mispredict_count    saturating count of mispredicts

// Per-way tag comparator used by the lookup path.
module btb_way_match #(
  parameter int TAG_W = 26
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag_s,
  input  logic [TAG_W-1:0] tag_i,
  output logic             match
);
  assign match = vld && (tag_s == tag_i);
endmodule

module btb_sa_predictor #(
  parameter int                  XLEN     = 32,
  parameter int                  SETS     = 16,
  parameter int                  WAYS     = 2,
  parameter int                  CTR_BITS = 2,
  parameter logic [CTR_BITS-1:0] INIT_CTR = {1'b1, {(CTR_BITS-1){1'b0}}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_fetch,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_en,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_mispredict,
  output logic [31:0]     mispredict_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - 2;
  // With a single way the pointer degenerates to a constant-0 bit.
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [SETS-1:0][WAYS-1:0]                valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]     tag_q,   tag_d;
  logic [SETS-1:0][WAYS-1:0][XLEN-1:0]      tgt_q,   tgt_d;
  logic [SETS-1:0][WAYS-1:0][CTR_BITS-1:0]  ctr_q,   ctr_d;
  logic [SETS-1:0][WAY_W-1:0]               ptr_q,   ptr_d;
  logic [31:0]                              mcnt_q,  mcnt_d;

  // Byte-offset bits of the PCs never reach the tables.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{pc_fetch[1:0], update_pc[1:0]};

  // ---------------- lookup (state before this edge, no bypass) -----------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic [WAYS-1:0]  f_match;
  logic             f_hit;
  logic [WAY_W-1:0] f_way;

  assign f_idx = pc_fetch[IDX_W+1:2];
  assign f_tag = pc_fetch[XLEN-1:IDX_W+2];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    btb_way_match #(.TAG_W(TAG_W)) u_match (
      .vld   (valid_q[f_idx][g]),
      .tag_s (tag_q[f_idx][g]),
      .tag_i (f_tag),
      .match (f_match[g])
    );
  end

  // Scan high to low so the lowest matching way is the one left standing.
  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (f_match[w]) begin
        f_hit = 1'b1;
        f_way = WAY_W'(w);
      end
    end
  end

  assign pred_hit    = f_hit;
  assign pred_taken  = f_hit && ctr_q[f_idx][f_way][CTR_BITS-1];
  assign pred_target = pred_taken ? tgt_q[f_idx][f_way] : pc_fetch + XLEN'(4);

  // ---------------- update ------------------------------------------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit, u_inv;
  logic [WAY_W-1:0] u_way, u_inv_way, u_vic;

  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[XLEN-1:IDX_W+2];

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    u_inv     = 1'b0;
    u_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!valid_q[u_idx][w]) begin
        u_inv     = 1'b1;
        u_inv_way = WAY_W'(w);
      end
    end
    u_vic = u_inv ? u_inv_way : ptr_q[u_idx];
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    ptr_d   = ptr_q;
    mcnt_d  = mcnt_q;

    if (flush) begin
      valid_d = '0;
    end else if (update_en) begin
      if (u_hit) begin
        if (update_taken) begin
          if (ctr_q[u_idx][u_way] != CTR_MAX)
            ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] + CTR_BITS'(1);
          tgt_d[u_idx][u_way] = update_target;
        end else if (ctr_q[u_idx][u_way] != '0) begin
          ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] - CTR_BITS'(1);
        end
      end else if (update_taken) begin
        valid_d[u_idx][u_vic] = 1'b1;
        tag_d[u_idx][u_vic]   = u_tag;
        tgt_d[u_idx][u_vic]   = update_target;
        ctr_d[u_idx][u_vic]   = INIT_CTR;
        // Only evicting a live entry moves the round-robin pointer.
        if (!u_inv)
          ptr_d[u_idx] = (ptr_q[u_idx] == WAY_W'(WAYS - 1)) ? '0
                                                             : ptr_q[u_idx] + WAY_W'(1);
      end
    end

    // Counts independently of flush.
    if (update_en && update_mispredict && (mcnt_q != 32'hFFFF_FFFF))
      mcnt_d = mcnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= '0;
      ptr_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      ptr_q   <= ptr_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_btb_sa_predictor.sv
// Scoreboard bench for btb_sa_predictor: the stimulus process asks a
// behavioural model for the expected lookup response and pushes it; the
// monitor pops and compares on the falling edge.
module tb_btb_sa_predictor;
  localparam int XLEN = 32, SETS = 16, WAYS = 2, CTR_BITS = 2;
  localparam int IDX_W = 4;
  localparam int CMAX = (1 << CTR_BITS) - 1;
  localparam int INIT = 2;

  logic            clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [XLEN-1:0] pc_fetch = '0;
  logic            pred_hit, pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            update_en = 1'b0, update_taken = 1'b0, update_mispredict = 1'b0;
  logic [XLEN-1:0] update_pc = '0, update_target = '0;
  logic [31:0]     mispredict_count;

  btb_sa_predictor #(.XLEN(XLEN), .SETS(SETS), .WAYS(WAYS), .CTR_BITS(CTR_BITS)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pc_fetch(pc_fetch),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_v   [SETS][WAYS];
  int unsigned m_tag [SETS][WAYS];   // pc >> (IDX_W+2)
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_ctr [SETS][WAYS];
  int          m_ptr [SETS];
  longint      m_mc;

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = '0; m_ctr[s][w] = 0;
      end
    end
    m_mc = 0;
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s, r;
    s = int'((pc >> 2) % SETS);
    r = -1;
    for (int w = 0; w < WAYS; w++)
      if (r < 0 && m_v[s][w] && m_tag[s][w] == (pc >> (IDX_W + 2))) r = w;
    return r;
  endfunction

  function automatic void m_update(input bit fl, input bit ue, input logic [31:0] pc,
                                   input bit tk, input logic [31:0] tg, input bit mis);
    int s, w;
    if (ue && mis && m_mc < 64'hFFFF_FFFF) m_mc++;
    if (fl) begin
      for (int i = 0; i < SETS; i++) for (int j = 0; j < WAYS; j++) m_v[i][j] = 0;
      return;
    end
    if (!ue) return;
    s = int'((pc >> 2) % SETS);
    w = m_find(pc);
    if (w >= 0) begin
      if (tk) begin
        m_ctr[s][w] = (m_ctr[s][w] + 1 > CMAX) ? CMAX : m_ctr[s][w] + 1;
        m_tgt[s][w] = tg;
      end else begin
        m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
      end
    end else if (tk) begin
      w = -1;
      for (int j = 0; j < WAYS; j++) if (w < 0 && !m_v[s][j]) w = j;
      if (w < 0) begin
        w = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % WAYS;
      end
      m_v[s][w] = 1; m_tag[s][w] = pc >> (IDX_W + 2); m_tgt[s][w] = tg; m_ctr[s][w] = INIT;
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          h;
    bit          t;
    logic [31:0] tg;
    logic [31:0] mc;
    int          cyc;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;

  task automatic step(input bit r, input bit fl, input bit ue, input logic [31:0] upc,
                      input bit tk, input logic [31:0] utg, input bit mis,
                      input logic [31:0] pcf);
    exp_t e;
    int w, s;
    rst = r; flush = fl; update_en = ue; update_pc = upc; update_taken = tk;
    update_target = utg; update_mispredict = mis; pc_fetch = pcf;
    if (r) m_reset();
    w = m_find(pcf);
    s = int'((pcf >> 2) % SETS);
    e.h   = (w >= 0);
    e.t   = (w >= 0) && (m_ctr[s][w] >= (1 << (CTR_BITS - 1)));
    e.tg  = e.t ? m_tgt[s][w] : pcf + 32'd4;
    e.mc  = m_mc[31:0];
    e.cyc = cyc;
    q.push_back(e);
    @(posedge clk);
    if (!r) m_update(fl, ue, upc, tk, utg, mis);
    cyc++;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg, input bit mis);
    step(0, 0, 1, pc, tk, tg, mis, pc);
  endtask

  task automatic look(input logic [31:0] pc);
    step(0, 0, 0, 32'h0, 0, 32'h0, 0, pc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      total += 4;
      if (pred_hit !== e.h) begin
        bad++; $display("FAIL hit cyc=%0d got=%b exp=%b", e.cyc, pred_hit, e.h);
      end
      if (pred_taken !== e.t) begin
        bad++; $display("FAIL taken cyc=%0d got=%b exp=%b", e.cyc, pred_taken, e.t);
      end
      if (pred_target !== e.tg) begin
        bad++; $display("FAIL target cyc=%0d got=%h exp=%h", e.cyc, pred_target, e.tg);
      end
      if (mispredict_count !== e.mc) begin
        bad++; $display("FAIL mcount cyc=%0d got=%0d exp=%0d", e.cyc, mispredict_count, e.mc);
      end
    end
  end

  initial begin
    logic [31:0] pc, tg;
    bit fl, ue, mis;
    m_reset();
    @(posedge clk); #1;
    // cold / reset
    step(1, 0, 0, 0, 0, 0, 0, 32'h100);
    look(32'h100);
    // alloc, predict, decay
    upd(32'h100, 1, 32'h40, 0);
    look(32'h100);
    upd(32'h100, 0, 32'h0, 0);
    upd(32'h100, 0, 32'h0, 0);
    look(32'h100);
    // saturation
    repeat (5) upd(32'h100, 1, 32'h40, 0);
    upd(32'h100, 0, 32'h0, 0);
    look(32'h100);
    // same-set replacement
    upd(32'h500, 1, 32'h50, 0);
    upd(32'h900, 1, 32'h90, 0);
    look(32'h100); look(32'h500); look(32'h900);
    upd(32'hD00, 1, 32'hD0, 0);
    look(32'h500); look(32'h900); look(32'hD00);
    // flush beats a same-cycle update
    step(0, 1, 1, 32'h200, 1, 32'h20, 0, 32'h900);
    look(32'h200); look(32'h900); look(32'hD00);
    upd(32'h300, 0, 32'h30, 0);
    look(32'h300);
    // mispredict counting
    upd(32'h104, 1, 32'h60, 1);
    upd(32'h104, 1, 32'h60, 1);
    upd(32'h104, 0, 32'h60, 1);
    step(0, 0, 0, 32'h104, 1, 32'h60, 1, 32'h104);
    look(32'h104);
    // address-space wrap on fall-through target
    look(32'hFFFF_FFFC);
    upd(32'hFFFF_FFFC, 1, 32'h1234, 0);
    look(32'hFFFF_FFFC);
    // reset in the middle of live state
    step(1, 0, 1, 32'h104, 1, 32'h70, 1, 32'h104);
    look(32'h104);
    // randomized traffic on a small address pool
    for (int i = 0; i < 600; i++) begin
      pc  = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2);
      tg  = $urandom & 32'hFFFF_FFFC;
      fl  = ($urandom_range(0, 29) == 0);
      ue  = $urandom_range(0, 1) == 1;
      mis = !fl && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 249) == 0)
        step(1, 0, 0, 0, 0, 0, 0, pc);
      else
        step(0, fl, ue, pc, $urandom_range(0, 2) != 0, tg, mis,
             $urandom_range(0, 1) ? pc
                                  : ((32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2)));
    end
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=hang exp=finish");
    $fatal(1, "timeout");
  end
endmodule
